// File: rtl/bist_checker.sv
// Memory BIST read-back checker: compares read beats against the selected
// pattern and accumulates error count, sticky fail bits and first-fail info.
module bist_checker #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [2:0]        q_i,
  input  logic              rd_valid_i,
  input  logic [7:0]        rd_data_i,
  output logic [7:0]        exp_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [CNT_W-1:0]  err_count_o,
  output logic [7:0]        fail_bits_o,
  output logic [ADDR_W-1:0] first_fail_addr_o,
  output logic [7:0]        first_fail_data_o
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ELEM_W = 4;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [DATA_W-1:0]   fail_bits_q, fail_bits_d;
  logic [ADDR_W-1:0]   ffa_q, ffa_d;
  logic [DATA_W-1:0]   ffd_q, ffd_d;
  logic                seen_q, seen_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ELEM_W-1:0]   last_elem_c;
  logic [DATA_W-1:0]   exp_c;

  // Pattern table: static patterns are single-element, march patterns alternate per element
  always_comb begin
    last_elem_c = '0;
    exp_c       = '0;
    case (sel_q)
      3'b000: exp_c = 8'hAA;
      3'b001: exp_c = 8'h55;
      3'b010: exp_c = 8'hF0;
      3'b011: exp_c = 8'h0F;
      3'b100: exp_c = 8'h00;
      3'b101: exp_c = 8'hFF;
      3'b110: begin
        last_elem_c = ELEM_W'(10);
        exp_c       = elem_q[0] ? 8'hFF : 8'h00;
      end
      default: begin
        last_elem_c = ELEM_W'(4);
        exp_c       = elem_q[0] ? 8'hFF : 8'h00;
      end
    endcase
    if (state_q != CHECK) exp_c = '0;
  end

  assign exp_data_o = exp_c;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    elem_d      = elem_q;
    err_d       = err_q;
    fail_bits_d = fail_bits_q;
    ffa_d       = ffa_q;
    ffd_d       = ffd_q;
    seen_d      = seen_q;
    case (state_q)
      CHECK: begin
        if (rd_valid_i) begin
          if (rd_data_i != exp_c) begin
            if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
            fail_bits_d = fail_bits_q | (rd_data_i ^ exp_c);
            if (!seen_q) begin
              ffa_d  = addr_q;
              ffd_d  = rd_data_i;
              seen_d = 1'b1;
            end
          end
          addr_d = addr_q + ADDR_W'(1);
          if (addr_q == ADDR_LAST) begin
            elem_d = elem_q + ELEM_W'(1);
            if (elem_q == last_elem_c) state_d = DONE;
          end
        end
      end
      default: begin
        // A start accepted together with rd_valid discards that beat
        if (start_i) begin
          state_d     = CHECK;
          sel_d       = q_i;
          addr_d      = '0;
          elem_d      = '0;
          err_d       = '0;
          fail_bits_d = '0;
          ffa_d       = '0;
          ffd_d       = '0;
          seen_d      = 1'b0;
        end
      end
    endcase
    busy_d = (state_d == CHECK);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      elem_q      <= '0;
      err_q       <= '0;
      fail_bits_q <= '0;
      ffa_q       <= '0;
      ffd_q       <= '0;
      seen_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      elem_q      <= elem_d;
      err_q       <= err_d;
      fail_bits_q <= fail_bits_d;
      ffa_q       <= ffa_d;
      ffd_q       <= ffd_d;
      seen_q      <= seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign err_count_o       = err_q;
  assign fail_bits_o       = fail_bits_q;
  assign first_fail_addr_o = ffa_q;
  assign first_fail_data_o = ffd_q;

endmodule

// File: tb/tb_bist_checker.sv
// Scoreboard bench for bist_checker: drivers queue expected run results,
// a monitor pops and compares them whenever done rises.
module tb_bist_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] q;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [7:0] exp_data;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [7:0] fail_bits;
  logic [3:0] ffa;
  logic [7:0] ffd;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       pass;
    logic [3:0] err;
    logic [7:0] fb;
    logic [3:0] ffa;
    logic [7:0] ffd;
  } res_t;

  res_t exp_q[$];

  bist_checker #(.ADDR_W(4), .CNT_W(4)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .start_i           (start),
    .q_i               (q),
    .rd_valid_i        (rd_valid),
    .rd_data_i         (rd_data),
    .exp_data_o        (exp_data),
    .busy_o            (busy),
    .done_o            (done),
    .pass_o            (pass),
    .err_count_o       (err_count),
    .fail_bits_o       (fail_bits),
    .first_fail_addr_o (ffa),
    .first_fail_data_o (ffd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Monitor: compare final results on each rising edge of done
  logic prev_done = 1'b0;
  res_t r;
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        r = exp_q.pop_front();
        check("pass",            32'(pass),      32'(r.pass));
        check("err_count",       32'(err_count), 32'(r.err));
        check("fail_bits",       32'(fail_bits), 32'(r.fb));
        check("first_fail_addr", 32'(ffa),       32'(r.ffa));
        check("first_fail_data", 32'(ffd),       32'(r.ffd));
      end
    end
    prev_done <= done;
  end

  task automatic push(input logic p, input logic [3:0] e, input logic [7:0] fb,
                      input logic [3:0] a, input logic [7:0] d);
    res_t x;
    x.pass = p; x.err = e; x.fb = fb; x.ffa = a; x.ffd = d;
    exp_q.push_back(x);
  endtask

  task automatic do_start(input logic [2:0] sel, input logic with_beat);
    start    = 1'b1;
    q        = sel;
    rd_valid = with_beat;
    rd_data  = 8'h00;
    @(negedge clk);
    start    = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic [7:0] e, input int gap);
    check("exp_data", 32'(exp_data), 32'(e));
    rd_valid = 1'b1;
    rd_data  = d;
    @(negedge clk);
    rd_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done) check(name, 32'(done), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_pass"}, 32'(pass), 32'(0));
    check({tag, "_err"},  32'(err_count), 32'(0));
    check({tag, "_fb"},   32'(fail_bits), 32'(0));
    check({tag, "_ffa"},  32'(ffa), 32'(0));
    check({tag, "_ffd"},  32'(ffd), 32'(0));
    check({tag, "_exp"},  32'(exp_data), 32'(0));
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] e;
    rst_n = 1'b0; start = 1'b0; q = 3'b000; rd_valid = 1'b0; rd_data = 8'h00;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean static 0xAA run
    push(1'b1, 4'd0, 8'h00, 4'd0, 8'h00);
    do_start(3'b000, 1'b0);
    check("busy_after_start", 32'(busy), 32'(1));
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("done_before_last", 32'(done), 32'(0));
      beat(8'hAA, 8'hAA, 0);
    end
    wait_done("timeout_run1");

    // DONE ignores rd_valid and holds results
    for (int i = 0; i < 3; i++) beat(8'h00, 8'h00, 0);
    check("hold_err", 32'(err_count), 32'(0));
    check("hold_pass", 32'(pass), 32'(1));
    check("hold_done", 32'(done), 32'(1));

    // Two mismatches; start cycle carries a bad beat that must be discarded
    push(1'b0, 4'd2, 8'h81, 4'd5, 8'hAB);
    do_start(3'b000, 1'b1);
    for (int i = 0; i < 16; i++) begin
      d = (i == 5) ? 8'hAB : (i == 9) ? 8'h2A : 8'hAA;
      beat(d, 8'hAA, 0);
    end
    wait_done("timeout_run2");

    // March C- with gaps; stray start and q change mid-run
    push(1'b1, 4'd0, 8'h00, 4'd0, 8'h00);
    do_start(3'b111, 1'b0);
    for (int i = 0; i < 80; i++) begin
      e = ((i / 16) % 2 == 1) ? 8'hFF : 8'h00;
      if (i == 30) begin
        start = 1'b1; q = 3'b000;
        @(negedge clk);
        start = 1'b0;
      end
      if (i == 79) check("done_before_beat80", 32'(done), 32'(0));
      beat(e, e, int'($urandom_range(0, 3)));
    end
    wait_done("timeout_run3");

    // March A all zeros: odd elements mismatch, counter saturates
    push(1'b0, 4'd15, 8'hFF, 4'd0, 8'h00);
    do_start(3'b110, 1'b0);
    for (int i = 0; i < 176; i++) begin
      e = ((i / 16) % 2 == 1) ? 8'hFF : 8'h00;
      beat(8'h00, e, 0);
    end
    wait_done("timeout_run4");

    // Reset mid March C- run (one earlier mismatch so results are non-zero)
    do_start(3'b111, 1'b0);
    for (int i = 0; i < 40; i++) begin
      e = ((i / 16) % 2 == 1) ? 8'hFF : 8'h00;
      beat((i == 3) ? 8'h01 : e, e, 0);
    end
    check("pre_reset_err", 32'(err_count), 32'(1));
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'(0));

    push(1'b1, 4'd0, 8'h00, 4'd0, 8'h00);
    do_start(3'b101, 1'b0);
    for (int i = 0; i < 16; i++) beat(8'hFF, 8'hFF, 0);
    wait_done("timeout_run5");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
